xor_arbiter: RTL and testbench

XOR_ARBITER -- requirements
Module: xor_arbiter

---
 rtl/xor_arbiter_if.sv | 48 ++++
 rtl/xor_arbiter.sv | 179 +++++++++++++++++
 tb/tb_xor_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_arbiter_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : xor_arbiter_if
// Purpose  : Bundles the requester, shared-XOR-unit and response signals of
//            the two-requester XOR arbiter.
// Signals  : req_valid[1:0]   per-requester request, bit i = requester i
//            a0/b0, a1/b1     8-bit operands of requester 0 / 1
//            req_ready[1:0]   per-requester accept (one-hot or 00)
//            xor_a, xor_b     operands presented to the shared XOR unit
//            xor_out          combinational result of the shared XOR unit
//            resp_valid[1:0]  one-hot response strobe to the owner
//            resp_data        registered result shared by both requesters
//            resp_ready       response accept from the current owner
//            busy             arbiter is not idle
// Modports : slave  - the arbiter itself
//            master - the environment (requesters + XOR unit)
// Revision : 1.0  initial release
// ============================================================================
interface xor_arbiter_if;

  logic [1:0] req_valid;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic [1:0] req_ready;
  logic [7:0] xor_a;
  logic [7:0] xor_b;
  logic [7:0] xor_out;
  logic [1:0] resp_valid;
  logic [7:0] resp_data;
  logic       resp_ready;
  logic       busy;

  modport slave (
    input  req_valid, a0, b0, a1, b1, xor_out, resp_ready,
    output req_ready, xor_a, xor_b, resp_valid, resp_data, busy
  );

  modport master (
    output req_valid, a0, b0, a1, b1, xor_out, resp_ready,
    input  req_ready, xor_a, xor_b, resp_valid, resp_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/xor_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : xor_arbiter
// Purpose  : Arbitrates two requesters onto one shared 8-bit XOR unit.
//            A grant latches the winner's operands, spends one cycle in
//            EXEC while the external XOR unit evaluates, then holds the
//            registered result in RESP until the owner accepts it.
//            Simultaneous requests are resolved by a priority pointer that
//            flips to the non-owner after every completed response.
// Ports    : clk    - rising-edge clock
//            reset  - synchronous active-high reset
//            arb    - xor_arbiter_if.slave (request / XOR / response bus)
// Revision : 1.0  initial release
// ============================================================================
module xor_arbiter (
  input  wire logic    clk,
  input  wire logic    reset,
  xor_arbiter_if.slave arb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       prio_q;       // requester that wins a tie
  logic       prio_d;
  logic       owner_q;      // requester whose operation is in flight
  logic       owner_d;
  logic [7:0] op_a_q;
  logic [7:0] op_a_d;
  logic [7:0] op_b_q;
  logic [7:0] op_b_d;
  logic [7:0] resp_data_q;
  logic [7:0] resp_data_d;

  // --------------------------------------------------------------------------
  // Grant decode (IDLE only). Forced to 00 while reset is asserted so no
  // requester believes it was accepted on a reset edge.
  // --------------------------------------------------------------------------
  logic [1:0] grant;
  logic       accept;
  logic       grant_id;

  always_comb begin
    grant = 2'b00;
    if (!reset && (state_q == S_IDLE)) begin
      case (arb.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // grant is only ever non-zero for a requester whose valid bit is set
  assign accept   = |grant;
  assign grant_id = grant[1];

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (arb.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    arb.req_ready  = grant;
    arb.resp_valid = 2'b00;
    if (state_q == S_RESP) begin
      arb.resp_valid = owner_q ? 2'b10 : 2'b01;
    end
    arb.busy      = (state_q != S_IDLE);
    // XOR unit always sees the captured operands, never the live inputs
    arb.xor_a     = op_a_q;
    arb.xor_b     = op_b_q;
    arb.resp_data = resp_data_q;
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    resp_data_d = resp_data_q;

    if ((state_q == S_IDLE) && accept) begin
      op_a_d  = grant_id ? arb.a1 : arb.a0;
      op_b_d  = grant_id ? arb.b1 : arb.b0;
      owner_d = grant_id;
    end

    // The XOR unit has had the whole EXEC cycle to settle on op_a/op_b
    if (state_q == S_EXEC) begin
      resp_data_d = arb.xor_out;
    end

    if ((state_q == S_RESP) && arb.resp_ready) begin
      prio_d = ~owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q      <= 8'h00;
      op_b_q      <= 8'h00;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      resp_data_q <= 8'h00;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      resp_data_q <= resp_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol properties
  // --------------------------------------------------------------------------
  a_resp_valid_not_both : assert property (
    @(posedge clk) disable iff (reset) arb.resp_valid != 2'b11
  );

  a_no_ready_when_busy : assert property (
    @(posedge clk) disable iff (reset)
    (state_q != S_IDLE) |-> (arb.req_ready == 2'b00)
  );

  a_resp_data_stable : assert property (
    @(posedge clk) disable iff (reset)
    (state_q != S_EXEC) |=> $stable(resp_data_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_xor_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_xor_arbiter
// Purpose  : Self-checking bench for xor_arbiter. Directed scenarios plus a
//            randomized run compared against a transaction-level model.
//            The shared XOR unit is modelled here as a continuous XOR.
// Revision : 1.0  initial release
// ============================================================================
module tb_xor_arbiter;

  logic clk = 1'b0;
  logic reset;

  xor_arbiter_if arb ();

  xor_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb)
  );

  always #5 clk = ~clk;

  assign arb.xor_out = arb.xor_a ^ arb.xor_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Advance to just after the next rising edge (input drive point)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    arb.req_valid  = 2'b00;
    arb.resp_ready = 1'b0;
    arb.a0 = 8'h00; arb.b0 = 8'h00; arb.a1 = 8'h00; arb.b1 = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs one operation to completion and reports what was observed; the
  // caller decides what was expected. req_valid is left as driven.
  task automatic run_op(input logic [1:0] rv, output logic [1:0] g,
                        output logic [1:0] rvld, output logic [7:0] d,
                        output bit to);
    int k;
    to = 1'b0; g = 2'b00; rvld = 2'b00; d = 8'h00;
    arb.req_valid  = rv;
    arb.resp_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (arb.req_ready == 2'b00 && k < 10) begin
      tick(); @(negedge clk); k++;
    end
    if (arb.req_ready == 2'b00) begin
      to = 1'b1;
      tick();
      return;
    end
    g = arb.req_ready;
    tick();
    k = 0;
    @(negedge clk);
    while (arb.resp_valid == 2'b00 && k < 10) begin
      tick(); @(negedge clk); k++;
    end
    if (arb.resp_valid == 2'b00) to = 1'b1;
    rvld = arb.resp_valid;
    d    = arb.resp_data;
    tick();
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    arb.req_valid  = 2'b11;
    arb.resp_ready = 1'b0;
    arb.a0 = 8'h12; arb.b0 = 8'h34; arb.a1 = 8'h56; arb.b1 = 8'h78;
    tick();
    @(negedge clk);
    n_checks++; if (arb.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", arb.req_ready); end
    n_checks++; if (arb.resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 00", arb.resp_valid); end
    n_checks++; if (arb.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", arb.busy); end
    n_checks++; if (arb.resp_data !== 8'h00) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 00", arb.resp_data); end
    n_checks++; if ({arb.xor_a, arb.xor_b} !== 16'h0000) begin n_fail++; $display("FAIL reset_xor_ops: got %h expected 0000", {arb.xor_a, arb.xor_b}); end
    tick();
    reset         = 1'b0;
    arb.req_valid = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    arb.req_valid = 2'b01; arb.a0 = 8'h55; arb.b0 = 8'h50;
    @(negedge clk);
    n_checks++; if (arb.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready: got %b expected 01", arb.req_ready); end
    tick();
    arb.req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (arb.resp_valid !== 2'b00 || arb.busy !== 1'b1) begin n_fail++; $display("FAIL single_exec: got rv=%b busy=%b expected rv=00 busy=1", arb.resp_valid, arb.busy); end
    n_checks++; if ({arb.xor_a, arb.xor_b} !== 16'h5550) begin n_fail++; $display("FAIL single_xor_ops: got %h expected 5550", {arb.xor_a, arb.xor_b}); end
    tick();
    @(negedge clk);
    n_checks++; if (arb.resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid: got %b expected 01", arb.resp_valid); end
    n_checks++; if (arb.resp_data !== 8'h05) begin n_fail++; $display("FAIL single_resp_data: got %h expected 05", arb.resp_data); end
    arb.resp_ready = 1'b1;
    tick();
    arb.resp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (arb.busy !== 1'b0 || arb.resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_done: got busy=%b rv=%b expected busy=0 rv=00", arb.busy, arb.resp_valid); end
    tick();
  endtask

  task automatic test_tie();
    logic [1:0] g, rv; logic [7:0] d; bit to;
    do_reset();
    arb.a0 = 8'hFF; arb.b0 = 8'h0F; arb.a1 = 8'hAA; arb.b1 = 8'hAA;
    run_op(2'b11, g, rv, d, to);
    n_checks++; if (to || g !== 2'b01 || rv !== 2'b01 || d !== 8'hF0) begin n_fail++; $display("FAIL tie_first: got to=%0d g=%b rv=%b d=%h expected g=01 rv=01 d=f0", to, g, rv, d); end
    run_op(2'b11, g, rv, d, to);
    arb.req_valid = 2'b00;
    n_checks++; if (to || g !== 2'b10 || rv !== 2'b10 || d !== 8'h00) begin n_fail++; $display("FAIL tie_second: got to=%0d g=%b rv=%b d=%h expected g=10 rv=10 d=00", to, g, rv, d); end
    arb.resp_ready = 1'b0;
  endtask

  task automatic test_fairness();
    logic [1:0] g, rv, exp_g; logic [7:0] d, exp_d; bit to;
    do_reset();
    arb.a0 = 8'h11; arb.b0 = 8'h22; arb.a1 = 8'h44; arb.b1 = 8'h11;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_d = (i % 2 == 1) ? (8'h44 ^ 8'h11) : (8'h11 ^ 8'h22);
      run_op(2'b11, g, rv, d, to);
      n_checks++; if (to || g !== exp_g || rv !== exp_g || d !== exp_d) begin n_fail++; $display("FAIL fair_op%0d: got to=%0d g=%b rv=%b d=%h expected g=%b d=%h", i, to, g, rv, d, exp_g, exp_d); end
    end
    arb.req_valid  = 2'b00;
    arb.resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    arb.req_valid = 2'b10; arb.a1 = 8'h12; arb.b1 = 8'h34;
    @(negedge clk);
    n_checks++; if (arb.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_req_ready: got %b expected 10", arb.req_ready); end
    tick();
    arb.req_valid = 2'b00;
    tick();
    // a request raised while busy must wait
    arb.req_valid = 2'b01; arb.a0 = 8'h0F; arb.b0 = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (arb.resp_valid !== 2'b10 || arb.resp_data !== 8'h26 || arb.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold%0d: got rv=%b d=%h rr=%b expected rv=10 d=26 rr=00", i, arb.resp_valid, arb.resp_data, arb.req_ready); end
      tick();
    end
    arb.resp_ready = 1'b1;
    tick();
    arb.resp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (arb.busy !== 1'b0 || arb.req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_release: got busy=%b rr=%b expected busy=0 rr=01", arb.busy, arb.req_ready); end
    tick();
    arb.req_valid = 2'b00;
    tick();
    @(negedge clk);
    n_checks++; if (arb.resp_valid !== 2'b01 || arb.resp_data !== 8'h0E) begin n_fail++; $display("FAIL bp_waiter: got rv=%b d=%h expected rv=01 d=0e", arb.resp_valid, arb.resp_data); end
    arb.resp_ready = 1'b1;
    tick();
    arb.resp_ready = 1'b0;
  endtask

  task automatic test_operand_hold();
    do_reset();
    arb.req_valid = 2'b10; arb.a1 = 8'h3C; arb.b1 = 8'h00;
    @(negedge clk);
    n_checks++; if (arb.req_ready !== 2'b10) begin n_fail++; $display("FAIL hold_req_ready: got %b expected 10", arb.req_ready); end
    tick();
    arb.req_valid = 2'b00; arb.a1 = 8'hC3;
    tick();
    @(negedge clk);
    n_checks++; if (arb.resp_valid !== 2'b10 || arb.resp_data !== 8'h3C) begin n_fail++; $display("FAIL hold_result: got rv=%b d=%h expected rv=10 d=3c", arb.resp_valid, arb.resp_data); end
    arb.resp_ready = 1'b1;
    tick();
    arb.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    logic [1:0] g, rv; logic [7:0] d; bit to;
    do_reset();
    arb.req_valid = 2'b01; arb.a0 = 8'hAA; arb.b0 = 8'h55;
    tick();
    arb.req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (arb.busy !== 1'b0 || arb.resp_valid !== 2'b00 || arb.resp_data !== 8'h00 || arb.xor_a !== 8'h00) begin n_fail++; $display("FAIL rst_exec_clear: got busy=%b rv=%b d=%h xa=%h expected 0 00 00 00", arb.busy, arb.resp_valid, arb.resp_data, arb.xor_a); end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_checks++; if (arb.resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_exec_noresp%0d: got %b expected 00", i, arb.resp_valid); end
    end
    tick();
    arb.a0 = 8'h0F; arb.b0 = 8'hF0;
    run_op(2'b01, g, rv, d, to);
    arb.req_valid  = 2'b00;
    arb.resp_ready = 1'b0;
    n_checks++; if (to || g !== 2'b01 || rv !== 2'b01 || d !== 8'hFF) begin n_fail++; $display("FAIL rst_exec_after: got to=%0d g=%b rv=%b d=%h expected g=01 rv=01 d=ff", to, g, rv, d); end
  endtask

  // Transaction-level model: an outstanding job is either "computing"
  // (first cycle after grant) or "answered" (result visible until taken).
  task automatic test_random();
    bit         m_pending, m_computing, m_owner, m_prio;
    logic [7:0] m_a, m_b, m_rdata;
    logic [1:0] exp_g, exp_rv, rvin;
    do_reset();
    m_pending = 0; m_computing = 0; m_owner = 0; m_prio = 0;
    m_a = 0; m_b = 0; m_rdata = 0;
    for (int c = 0; c < 400; c++) begin
      rvin           = 2'($urandom_range(0, 3));
      arb.req_valid  = rvin;
      arb.a0 = 8'($urandom); arb.b0 = 8'($urandom);
      arb.a1 = 8'($urandom); arb.b1 = 8'($urandom);
      arb.resp_ready = ($urandom_range(0, 3) != 0);
      reset          = ($urandom_range(0, 39) == 0);

      exp_g = 2'b00;
      if (!reset && !m_pending && rvin != 2'b00) begin
        if (rvin == 2'b11) exp_g = m_prio ? 2'b10 : 2'b01;
        else               exp_g = rvin;
      end
      exp_rv = (m_pending && !m_computing) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;

      @(negedge clk);
      n_checks++; if (arb.req_ready !== exp_g) begin n_fail++; $display("FAIL rand_req_ready c=%0d: got %b expected %b", c, arb.req_ready, exp_g); end
      n_checks++; if (arb.resp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_resp_valid c=%0d: got %b expected %b", c, arb.resp_valid, exp_rv); end
      n_checks++; if (arb.resp_data !== m_rdata) begin n_fail++; $display("FAIL rand_resp_data c=%0d: got %h expected %h", c, arb.resp_data, m_rdata); end
      n_checks++; if (arb.busy !== m_pending) begin n_fail++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, arb.busy, m_pending); end
      n_checks++; if ({arb.xor_a, arb.xor_b} !== {m_a, m_b}) begin n_fail++; $display("FAIL rand_xor_ops c=%0d: got %h expected %h", c, {arb.xor_a, arb.xor_b}, {m_a, m_b}); end

      if (reset) begin
        m_pending = 0; m_computing = 0; m_prio = 0;
        m_a = 0; m_b = 0; m_rdata = 0;
      end else if (exp_g != 2'b00) begin
        m_owner     = exp_g[1];
        m_a         = m_owner ? arb.a1 : arb.a0;
        m_b         = m_owner ? arb.b1 : arb.b0;
        m_pending   = 1;
        m_computing = 1;
      end else if (m_computing) begin
        m_computing = 0;
        m_rdata     = m_a ^ m_b;
      end else if (m_pending && arb.resp_ready) begin
        m_pending = 0;
        m_prio    = ~m_owner;
      end
      tick();
    end
    reset          = 1'b0;
    arb.req_valid  = 2'b00;
    arb.resp_ready = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    arb.req_valid  = 2'b00;
    arb.resp_ready = 1'b0;
    arb.a0 = 8'h00; arb.b0 = 8'h00; arb.a1 = 8'h00; arb.b1 = 8'h00;
    tick();
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_backpressure();
    test_operand_hold();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
